// File: rtl/csi_raw10_pkg.sv
// csi_raw10_pkg -- shared constants and helpers for the CSI-2 RAW10 packer.
//
// Contents:
//   - Pixel/group/buffer geometry (PIX_W, PIX_PER_GROUP, BYTES_PER_GROUP, BUF_BYTES).
//   - CSI-2 payload CRC-16 constants (reflected poly 0x8408, init 0xFFFF).
//   - pack_group : 4 x 10-bit pixels -> 5 RAW10 bytes, byte 0 in bits [7:0].
//   - crc16_byte : one byte of the reflected CRC-16, LSB first.
package csi_raw10_pkg;

  localparam int PIX_W           = 10;
  localparam int PIX_PER_GROUP   = 4;
  localparam int BYTES_PER_GROUP = 5;
  localparam int BUF_BYTES       = 8;

  localparam logic [15:0] CRC16_POLY_REFL = 16'h8408;
  localparam logic [15:0] CRC16_INIT      = 16'hFFFF;

  typedef logic [7:0] byte_t;

  // Input pixel i sits at the top of the group word (P0 = [39:30]). The first
  // four bytes carry the 8 MSBs of each pixel; the fifth collects the 2 LSBs,
  // with P0 in the lowest pair.
  function automatic logic [8*BYTES_PER_GROUP-1:0] pack_group(
    input logic [PIX_W*PIX_PER_GROUP-1:0] pix
  );
    logic [8*BYTES_PER_GROUP-1:0] packed_bytes;
    logic [7:0]                   lsb_byte;
    packed_bytes = '0;
    lsb_byte     = '0;
    for (int i = 0; i < PIX_PER_GROUP; i++) begin
      packed_bytes[8*i +: 8] = pix[(PIX_PER_GROUP-1-i)*PIX_W + 2 +: 8];
      lsb_byte[2*i +: 2]     = pix[(PIX_PER_GROUP-1-i)*PIX_W +: 2];
    end
    packed_bytes[8*PIX_PER_GROUP +: 8] = lsb_byte;
    return packed_bytes;
  endfunction

  function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in, input byte_t data);
    logic [15:0] crc;
    crc = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (crc[0] ^ data[i]) begin
        crc = (crc >> 1) ^ CRC16_POLY_REFL;
      end else begin
        crc = crc >> 1;
      end
    end
    return crc;
  endfunction

endpackage

// File: rtl/csi_raw10_packer_if.sv
// csi_raw10_packer_if -- pixel-group input stream and packed-word output stream.
//
// Signals:
//   pix_valid_i / pix_ready_o / pix_i[39:0] / pix_last_i : pixel group handshake
//   out_valid_o / out_ready_i / out_data_o[31:0] / out_keep_o[3:0] / out_last_o
//   line_bytes_o[LINE_BYTES_W-1:0]                     : byte count with last word
//   crc_o[15:0]                                        : only with CSI_RAW10_PACKER_CRC_EN
// Modports:
//   slave  : the packer side
//   master : the pixel source / word sink side
interface csi_raw10_packer_if #(
  parameter int LINE_BYTES_W = 16
);
  logic                    pix_valid_i;
  logic                    pix_ready_o;
  logic [39:0]             pix_i;
  logic                    pix_last_i;
  logic                    out_valid_o;
  logic                    out_ready_i;
  logic [31:0]             out_data_o;
  logic [3:0]              out_keep_o;
  logic                    out_last_o;
  logic [LINE_BYTES_W-1:0] line_bytes_o;
`ifdef CSI_RAW10_PACKER_CRC_EN
  logic [15:0]             crc_o;
`endif

  modport slave (
    input  pix_valid_i, pix_i, pix_last_i, out_ready_i,
    output pix_ready_o, out_valid_o, out_data_o, out_keep_o, out_last_o,
`ifdef CSI_RAW10_PACKER_CRC_EN
    output crc_o,
`endif
    output line_bytes_o
  );

  modport master (
    output pix_valid_i, pix_i, pix_last_i, out_ready_i,
    input  pix_ready_o, out_valid_o, out_data_o, out_keep_o, out_last_o,
`ifdef CSI_RAW10_PACKER_CRC_EN
    input  crc_o,
`endif
    input  line_bytes_o
  );

endinterface

// File: rtl/csi_crc16_4b.sv
// csi_crc16_4b -- combinational CSI-2 CRC-16 update over up to 4 bytes.
//
// Ports:
//   crc_i[15:0]  : running CRC before this word
//   data_i[31:0] : word, byte 0 in [7:0] is processed first
//   keep_i[3:0]  : byte enables; disabled bytes leave the CRC untouched
//   crc_o[15:0]  : CRC after the enabled bytes
module csi_crc16_4b
  import csi_raw10_pkg::*;
(
  input  logic [15:0] crc_i,
  input  logic [31:0] data_i,
  input  logic [3:0]  keep_i,
  output logic [15:0] crc_o
);

  logic [15:0] stage [0:4];

  assign stage[0] = crc_i;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_byte
      assign stage[gi+1] = keep_i[gi] ? crc16_byte(stage[gi], data_i[8*gi +: 8]) : stage[gi];
    end
  endgenerate

  assign crc_o = stage[4];

endmodule

// File: rtl/csi_raw10_packer.sv
// csi_raw10_packer -- packs 4 x 10-bit pixel groups into the CSI-2 RAW10 byte
// stream, emitted as 32-bit words (lane 0 in [7:0]).
//
// Ports:
//   wb_clk_i : clock
//   wb_rst_i : synchronous active-high reset; drops any buffered bytes
//   bus      : csi_raw10_packer_if.slave (pixel input + packed word output)
// Parameters:
//   LINE_BYTES_W : width of the per-line payload byte counter
// Build option:
//   CSI_RAW10_PACKER_CRC_EN : adds crc_o, the CSI-2 payload CRC-16 of the line,
//                             presented alongside out_last_o.
//
// The 8-byte buffer keeps every byte above its occupancy at zero, so the low
// word can be presented directly: a partial final word gets zero fill for free.
module csi_raw10_packer
  import csi_raw10_pkg::*;
#(
  parameter int LINE_BYTES_W = 16
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  csi_raw10_packer_if.slave bus
);

  localparam int         BUF_W        = 8 * BUF_BYTES;
  localparam int         GROUP_W      = 8 * BYTES_PER_GROUP;
  localparam logic [3:0] WORD_BYTES_N = 4'd4;

  logic [BUF_W-1:0]        buf_reg, buf_next, base_buf;
  logic [3:0]              cnt_reg, cnt_next, base_cnt;
  logic                    flush_reg, flush_next;
  logic [LINE_BYTES_W-1:0] line_cnt_reg, line_cnt_next;

  logic                    out_valid, out_last, fire, pix_ready, accept;
  logic [3:0]              out_keep;
  logic [31:0]             out_data;
  logic [GROUP_W-1:0]      group_bytes;

  assign out_valid = (cnt_reg >= WORD_BYTES_N) || (flush_reg && (cnt_reg != 4'd0));
  // During flush no new bytes arrive, so the word holding the last <=4 bytes ends the line.
  assign out_last  = out_valid && flush_reg && (cnt_reg <= WORD_BYTES_N);
  assign fire      = out_valid && bus.out_ready_i;
  // With a word leaving this cycle, up to 7 bytes still leave room for 5 more.
  assign pix_ready = !wb_rst_i && !flush_reg &&
                     ((cnt_reg <= 4'd3) || ((cnt_reg <= 4'd7) && fire));
  assign accept    = bus.pix_valid_i && pix_ready;

  assign group_bytes = pack_group(bus.pix_i);

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_keep
      assign out_keep[gi] = out_valid && (cnt_reg > 4'(gi));
    end
  endgenerate

  assign out_data = out_valid ? buf_reg[31:0] : '0;

  always_comb begin
    base_buf      = buf_reg;
    base_cnt      = cnt_reg;
    flush_next    = flush_reg;
    line_cnt_next = line_cnt_reg;

    if (fire) begin
      base_buf = buf_reg >> 32;
      base_cnt = (cnt_reg >= WORD_BYTES_N) ? (cnt_reg - WORD_BYTES_N) : 4'd0;
    end

    buf_next = base_buf;
    cnt_next = base_cnt;
    if (accept) begin
      // base_cnt <= 3 whenever a group is accepted, so the append always fits.
      buf_next = base_buf | ({{(BUF_W-GROUP_W){1'b0}}, group_bytes} << {base_cnt, 3'b000});
      cnt_next = base_cnt + 4'(BYTES_PER_GROUP);
    end

    if (accept && bus.pix_last_i) begin
      flush_next = 1'b1;
    end else if (fire && out_last) begin
      flush_next = 1'b0;
    end

    if (accept) begin
      line_cnt_next = line_cnt_reg + LINE_BYTES_W'(BYTES_PER_GROUP);
    end else if (fire && out_last) begin
      line_cnt_next = '0;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      buf_reg      <= '0;
      cnt_reg      <= '0;
      flush_reg    <= 1'b0;
      line_cnt_reg <= '0;
    end else begin
      buf_reg      <= buf_next;
      cnt_reg      <= cnt_next;
      flush_reg    <= flush_next;
      line_cnt_reg <= line_cnt_next;
    end
  end

  assign bus.pix_ready_o  = pix_ready;
  assign bus.out_valid_o  = out_valid;
  assign bus.out_data_o   = out_data;
  assign bus.out_keep_o   = out_keep;
  assign bus.out_last_o   = out_last;
  assign bus.line_bytes_o = out_last ? line_cnt_reg : '0;

`ifdef CSI_RAW10_PACKER_CRC_EN
  logic [15:0] crc_reg;
  logic [15:0] crc_word;

  csi_crc16_4b u_crc (
    .crc_i  (crc_reg),
    .data_i (out_data),
    .keep_i (out_keep),
    .crc_o  (crc_word)
  );

  // crc_reg holds the CRC of words already fired in this line; the last
  // word's bytes are folded in combinationally so crc_o covers the full line.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      crc_reg <= CRC16_INIT;
    end else if (fire) begin
      crc_reg <= out_last ? CRC16_INIT : crc_word;
    end
  end

  assign bus.crc_o = out_last ? crc_word : '0;
`endif

endmodule

// File: tb/tb_csi_raw10_packer.sv
// tb_csi_raw10_packer -- directed scenarios with a scoreboard. Stimulus pushes
// expected words into exp_q; a monitor on the falling edge pops and compares
// every word the DUT fires.
module tb_csi_raw10_packer;
  import csi_raw10_pkg::*;

  localparam int LBW = 16;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
    logic [15:0] lbytes;
    logic [15:0] crc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  csi_raw10_packer_if #(.LINE_BYTES_W(LBW)) bus ();

  csi_raw10_packer #(.LINE_BYTES_W(LBW)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  exp_t        exp_q[$];
  byte_t       pend[$];
  logic [15:0] m_line_cnt = 16'd0;
  logic [15:0] m_crc      = 16'hFFFF;
  int          checks     = 0;
  int          failures   = 0;
  int          cyc        = 0;
  int          fire_cnt   = 0;
  int          first_fire = -1;
  int          last_fire  = -1;
  logic [39:0] vec [0:7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  function automatic logic [15:0] crc_step(input logic [15:0] c_in, input logic [7:0] b);
    logic [15:0] c;
    logic        fb;
    c = c_in;
    for (int i = 0; i < 8; i++) begin
      fb = c[0] ^ b[i];
      c  = {1'b0, c[15:1]};
      if (fb) c = c ^ 16'h8408;
    end
    return c;
  endfunction

  task automatic push_word(input logic [31:0] d, input logic [3:0] k, input logic l,
                           input logic [15:0] lb, input logic [15:0] c);
    exp_t e;
    e.data = d; e.keep = k; e.last = l; e.lbytes = lb; e.crc = c;
    exp_q.push_back(e);
  endtask

  // Reference packing and line model: bytes accumulate in pend, full words
  // are expected as soon as 4 bytes exist, the tail word on the last group.
  task automatic model_group(input logic [39:0] p, input logic l);
    byte_t       b [5];
    logic [31:0] w;
    logic        fin;
    int          n;
    b[0] = p[39:32];
    b[1] = p[29:22];
    b[2] = p[19:12];
    b[3] = p[9:2];
    b[4] = {p[1:0], p[11:10], p[21:20], p[31:30]};
    for (int i = 0; i < 5; i++) begin
      pend.push_back(b[i]);
      m_crc = crc_step(m_crc, b[i]);
    end
    m_line_cnt = m_line_cnt + 16'd5;
    while (pend.size() >= 4) begin
      w = {pend[3], pend[2], pend[1], pend[0]};
      for (int i = 0; i < 4; i++) void'(pend.pop_front());
      fin = l && (pend.size() == 0);
      push_word(w, 4'hF, fin, fin ? m_line_cnt : 16'd0, fin ? m_crc : 16'd0);
    end
    if (l && (pend.size() > 0)) begin
      w = '0;
      n = pend.size();
      for (int i = 0; i < n; i++) w[8*i +: 8] = pend[i];
      push_word(w, 4'((1 << n) - 1), 1'b1, m_line_cnt, m_crc);
      pend.delete();
    end
    if (l) begin
      m_line_cnt = 16'd0;
      m_crc      = 16'hFFFF;
    end
  endtask

  // Present one group and hold it until accepted (bounded). Returns the
  // number of cycles pix_ready_o was low while the group waited.
  task automatic send_group(input logic [39:0] p, input logic l, input bit use_model,
                            output int waits);
    bit done;
    done  = 1'b0;
    waits = 0;
    bus.pix_valid_i = 1'b1;
    bus.pix_i       = p;
    bus.pix_last_i  = l;
    while (!done) begin
      @(negedge clk);
      if (bus.pix_ready_o) begin
        done = 1'b1;
        if (use_model) model_group(p, l);
      end else begin
        waits++;
      end
      @(posedge clk);
      #1;
      if (!done && waits >= 60) begin
        chk("accept_timeout", 64'(waits), 64'd0);
        done = 1'b1;
      end
    end
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_drained"}, 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string name);
    chk({name, "_out_valid"}, 64'(bus.out_valid_o), 64'd0);
    chk({name, "_pix_ready"}, 64'(bus.pix_ready_o), 64'd0);
    chk({name, "_out_data"}, 64'(bus.out_data_o), 64'd0);
    chk({name, "_out_keep"}, 64'(bus.out_keep_o), 64'd0);
    chk({name, "_out_last"}, 64'(bus.out_last_o), 64'd0);
    chk({name, "_line_bytes"}, 64'(bus.line_bytes_o), 64'd0);
`ifdef CSI_RAW10_PACKER_CRC_EN
    chk({name, "_crc"}, 64'(bus.crc_o), 64'd0);
`endif
  endtask

  // Single-group line with hand-computed words: 0x55AA00FF then 0x63 (keep 1).
  task automatic single_group_line(input string name);
    logic [15:0] c;
    int          w;
    c = 16'hFFFF;
    c = crc_step(c, 8'hFF);
    c = crc_step(c, 8'h00);
    c = crc_step(c, 8'hAA);
    c = crc_step(c, 8'h55);
    c = crc_step(c, 8'h63);
    push_word(32'h55AA00FF, 4'hF, 1'b0, 16'd0, 16'd0);
    push_word(32'h00000063, 4'h1, 1'b1, 16'd5, c);
    send_group({10'h3FF, 10'h000, 10'h2AA, 10'h155}, 1'b1, 1'b0, w);
    bus.pix_valid_i = 1'b0;
    chk({name, "_accept_wait"}, 64'(w), 64'd0);
    @(negedge clk);
    chk({name, "_latency_valid"}, 64'(bus.out_valid_o), 64'd1);
    wait_drain(name);
  endtask

  // Scoreboard monitor.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst && bus.out_valid_o && bus.out_ready_i) begin
        fire_cnt++;
        if (first_fire < 0) first_fire = cyc;
        last_fire = cyc;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word actual=0x%08h keep=0x%0h required=none",
                   bus.out_data_o, bus.out_keep_o);
        end else begin
          e = exp_q.pop_front();
          $display("word data=0x%08h keep=0x%0h last=%0d line_bytes=%0d",
                   bus.out_data_o, bus.out_keep_o, bus.out_last_o, bus.line_bytes_o);
          chk("word_data", 64'(bus.out_data_o), 64'(e.data));
          chk("word_keep", 64'(bus.out_keep_o), 64'(e.keep));
          chk("word_last", 64'(bus.out_last_o), 64'(e.last));
          if (e.last) begin
            chk("line_bytes", 64'(bus.line_bytes_o), 64'(e.lbytes));
`ifdef CSI_RAW10_PACKER_CRC_EN
            chk("line_crc", 64'(bus.crc_o), 64'(e.crc));
`endif
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          w;
    int          total;
    logic [31:0] sd;
    logic [3:0]  sk;
    bit          have;

    vec[0] = {10'h001, 10'h002, 10'h003, 10'h004};
    vec[1] = {10'h3FF, 10'h3FE, 10'h3FD, 10'h3FC};
    vec[2] = {10'h155, 10'h2AA, 10'h155, 10'h2AA};
    vec[3] = {10'h200, 10'h100, 10'h080, 10'h040};
    vec[4] = {10'h0F0, 10'h00F, 10'h3C3, 10'h123};
    vec[5] = {10'h000, 10'h000, 10'h000, 10'h001};
    vec[6] = {10'h2DE, 10'h1AD, 10'h0BE, 10'h3EF};
    vec[7] = {10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF};

    bus.pix_valid_i = 1'b0;
    bus.pix_i       = '0;
    bus.pix_last_i  = 1'b0;
    bus.out_ready_i = 1'b1;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Scenario 1: single-group line.
    single_group_line("s1");

    // Scenario 2: 4-group line, ready every time, 5 full words.
    fire_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      send_group(vec[i], (i == 3), 1'b1, w);
      chk($sformatf("s2_ready_g%0d", i), 64'(w), 64'd0);
    end
    bus.pix_valid_i = 1'b0;
    wait_drain("s2");
    chk("s2_word_count", 64'(fire_cnt), 64'd5);

    // Scenario 3: 8 groups back-to-back, no last; one stall on the 5th group.
    fire_cnt   = 0;
    first_fire = -1;
    total      = 0;
    for (int i = 0; i < 8; i++) begin
      send_group(vec[i], 1'b0, 1'b1, w);
      total += w;
      chk($sformatf("s3_wait_g%0d", i), 64'(w), (i == 4) ? 64'd1 : 64'd0);
    end
    bus.pix_valid_i = 1'b0;
    wait_drain("s3");
    chk("s3_stall_total", 64'(total), 64'd1);
    chk("s3_word_count", 64'(fire_cnt), 64'd10);
    chk("s3_word_span", 64'(last_fire - first_fire), 64'd9);

    // Scenario 4: out_ready_i low for 10 cycles mid-line.
    have = 1'b0;
    sd   = '0;
    sk   = '0;
    fork
      begin
        for (int i = 0; i < 3; i++) send_group(vec[i+2], (i == 2), 1'b1, w);
        bus.pix_valid_i = 1'b0;
      end
      begin
        bus.out_ready_i = 1'b0;
        repeat (10) begin
          @(negedge clk);
          if (bus.out_valid_o) begin
            if (!have) begin
              have = 1'b1;
              sd   = bus.out_data_o;
              sk   = bus.out_keep_o;
            end else begin
              chk("s4_data_stable", 64'(bus.out_data_o), 64'(sd));
              chk("s4_keep_stable", 64'(bus.out_keep_o), 64'(sk));
            end
            chk("s4_pix_ready_low", 64'(bus.pix_ready_o), 64'd0);
          end
        end
        chk("s4_valid_seen", 64'(have), 64'd1);
        @(posedge clk);
        #1;
        bus.out_ready_i = 1'b1;
      end
    join
    wait_drain("s4");

    // Scenario 5: leave 3 bytes buffered, reset, then a fresh single-group line.
    for (int i = 5; i < 8; i++) send_group(vec[i], 1'b0, 1'b1, w);
    bus.pix_valid_i = 1'b0;
    wait_drain("s5_pre");
    @(negedge clk);
    chk("s5_idle_partial", 64'(bus.out_valid_o), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_zero("s5_reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    pend.delete();
    m_line_cnt = 16'd0;
    m_crc      = 16'hFFFF;
    repeat (5) @(posedge clk);
    #1;
    single_group_line("s5");

    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/csi_raw10_packer.md
Name: csi_raw10_packer

Overview:
- Transmit-side counterpart of the CSI RAW10 unpacker.
- Accepts groups of 4 x 10-bit pixels and emits the CSI-2 RAW10 packed byte stream as 32-bit words, 4 lanes x 1 byte per word.
- Sits between the pixel source (test-pattern generator or LA/Wishbone loopback) and the lane serializer of the user project.
- Handles per-line flush with a partial final word, and reports the line byte count for the packet header.

Parameters:
- LINE_BYTES_W, 16, width of the per-line payload byte counter (CSI-2 word-count field width).

Ports:
- wb_clk_i  in  1  clock.
- wb_rst_i  in  1  synchronous, active-high reset.
- pix_valid_i  in  1  pixel group valid.
- pix_ready_o  out  1  pixel group accepted when valid and ready are both high.
- pix_i  in  40  [39:30]=P0, [29:20]=P1, [19:10]=P2, [9:0]=P3; P0 is the first pixel on the line.
- pix_last_i  in  1  group is the last of the line.
- out_valid_o  out  1  output word valid.
- out_ready_i  in  1  downstream accepts the word.
- out_data_o  out  32  [7:0] first byte on wire (lane 0) … [31:24] lane 3.
- out_keep_o  out  4  byte-valid mask; 4'hF except on a partial final word.
- out_last_o  out  1  final word of the line.
- line_bytes_o  out  LINE_BYTES_W  payload bytes in the line; valid while out_last_o is high.

Behaviour:
- **Reset:** every output is 0 after one wb_rst_i cycle. Buffer byte count N=0, flush flag cleared, line counter cleared. Reset mid-line discards all buffered data with no partial emission.
- **Group packing:** each group becomes 5 bytes, in order:
  - B0=P0[9:2], B1=P1[9:2], B2=P2[9:2], B3=P3[9:2]
  - B4={P3[1:0],P2[1:0],P1[1:0],P0[1:0]}
- **Buffer:** 64-bit byte FIFO-like shift buffer with occupancy N in 0..8.
  - New bytes append above the existing N bytes.
  - The output word is always the lowest 4 bytes.
- **Output valid:** out_valid_o = (N>=4) || (flush && N>0).
  - out_data_o and out_keep_o are registered from buffer state.
  - Output must hold stable while valid && !ready.
- **Input ready:** pix_ready_o = !flush && ((N<=3) || (N<=7 && out_valid_o && out_ready_i)).
  - This is the only combinational path from out_ready_i.
  - Same-cycle output fire and input accept: N_next = N - 4 + 5.
- **Flush:** accepting a group with pix_last_i sets flush.
  - While flush is set, words drain. A final word with N<4 has out_keep_o = (1<<N)-1 and its unused bytes are 0.
  - out_last_o is asserted on the word that empties the buffer; flush clears when that word fires.
  - Example: 1 group gives 5 bytes = a full word then a keep=4'h1 last word. 4 groups give 20 bytes = 5 full words, with the last flagged.
- **Throughput and latency:**
  - Sustained pix_valid_i with out_ready_i=1 gives 4 groups accepted per 5 cycles (output-limited), no bubbles on the output.
  - Latency from first accept to first out_valid_o is 1 cycle.
- **Line byte counter:**
  - Adds 5 per accepted group and wraps modulo 2^LINE_BYTES_W.
  - line_bytes_o presents the total with the last word; the counter clears when the last word fires.
- **Protocol violations:** pix_valid_i dropping without handshake is legal. Changing pix_i while valid && !ready is undefined.

Optional Feature:
- Macro: CSI_RAW10_PACKER_CRC_EN.
- **With the macro:**
  - Adds output crc_o[15:0], valid with out_last_o.
  - CRC is the CSI-2 payload CRC-16: poly x^16+x^12+x^5+1, reflected 0x8408, init 0xFFFF, LSB first.
  - It covers only the keep-enabled bytes of each fired word and re-initialises after the last word.
- **Without the macro:** no crc_o port and no CRC logic.

Decomposition:
- **Package csi_raw10_pkg:** PIX_W=10, PIX_PER_GROUP=4, BYTES_PER_GROUP=5, BUF_BYTES=8, CRC16_POLY_REFL=16'h8408, CRC16_INIT=16'hFFFF.
- **Sub-module csi_crc16_4b:** combinational next-CRC over up to 4 bytes with a keep mask. Instantiated only under CSI_RAW10_PACKER_CRC_EN.

Test Plan:
1. **Single-group line:** P0=3FF, P1=000, P2=2AA, P3=155, last=1.
   - Word 0x55AA00FF, keep F, last 0.
   - Then word 0x00000063, keep 1, last 1, line_bytes_o=5.
2. **4-group line, out_ready_i=1:** pix_ready_o high for all 4 accepts, exactly 5 full words emitted, last on word 5, line_bytes_o=20.
3. **8 back-to-back groups, no last, out_ready_i=1:** 10 words in 10 cycles, pix_ready_o low exactly once every 5 cycles, bytes match the reference packing model.
4. **Backpressure:** out_ready_i=0 for 10 cycles mid-line.
   - out_data_o/out_keep_o stable throughout; pix_ready_o=0 once N>=4 and stays 0 while stalled.
   - No byte lost or duplicated after release.
5. **Reset mid-line:** wb_rst_i pulsed with N=3, then a fresh 1-group line.
   - All outputs 0 during reset.
   - The next line reproduces scenario 1 exactly and line_bytes_o=5.
6. **CRC, with CSI_RAW10_PACKER_CRC_EN:** scenario 1 and scenario 2 lines.
   - crc_o at out_last_o equals a bit-serial 0x8408/0xFFFF model over the 5 and 20 payload bytes.
   - CRC resets between lines.
